// File: rtl/rank_order_filter.sv
// Rank-order filter: returns the sample of a runtime-selected rank from an N-sample window.
// The result leaves through a 3-stage valid/ready pipeline. RANK_ORDER_FILTER_MINMAX_EN adds dmin/dmax for the same window.
module rank_order_filter #(
  parameter  int unsigned WIDTH = 12,
  parameter  int unsigned N     = 9,
  localparam int unsigned RW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] din,
  input  logic [RW-1:0]      rank_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout,
  output logic [RW-1:0]      dout_idx
`ifdef RANK_ORDER_FILTER_MINMAX_EN
  ,
  output logic [WIDTH-1:0]   dmin,
  output logic [WIDTH-1:0]   dmax
`endif
);

  localparam logic [RW-1:0] RMAX = RW'(N - 1);

  typedef logic [N-1:0][WIDTH-1:0] win_t;
  typedef logic [N-1:0][N-1:0]     mat_t;
  typedef logic [N-1:0][RW-1:0]    rank_t;

  logic          adv;
  win_t          win_c;
  mat_t          lt_c;
  logic [RW-1:0] sel_c;
  rank_t         rank_c;

  logic          v1_q;
  win_t          win1_q;
  logic [RW-1:0] sel1_q;
  mat_t          lt1_q;

  logic          v2_q;
  win_t          win2_q;
  logic [RW-1:0] sel2_q;
  rank_t         rank2_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [RW-1:0]    dout_idx_q, dout_idx_d;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_idx  = dout_idx_q;

  assign win_c = din;
  assign sel_c = (rank_sel > RMAX) ? RMAX : rank_sel;

  // Pairwise order with the index as tie-break, which makes the ranks a permutation.
  always_comb begin
    lt_c = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if (i != j) begin
          lt_c[j][i] = (win_c[i] < win_c[j]) || ((win_c[i] == win_c[j]) && (i < j));
        end
      end
    end
  end

  // Rank of each sample = number of samples ordered below it.
  always_comb begin
    rank_c = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        rank_c[j] = rank_c[j] + RW'(lt1_q[j][i]);
      end
    end
  end

  // A no-match case would keep the previous result.
  always_comb begin
    dout_d     = dout_q;
    dout_idx_d = dout_idx_q;
    for (int j = 0; j < N; j++) begin
      if (rank2_q[j] == sel2_q) begin
        dout_d     = win2_q[j];
        dout_idx_d = RW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      win1_q      <= '0;
      sel1_q      <= '0;
      lt1_q       <= '0;
      v2_q        <= 1'b0;
      win2_q      <= '0;
      sel2_q      <= '0;
      rank2_q     <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_idx_q  <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      win1_q      <= win_c;
      sel1_q      <= sel_c;
      lt1_q       <= lt_c;
      v2_q        <= v1_q;
      win2_q      <= win1_q;
      sel2_q      <= sel1_q;
      rank2_q     <= rank_c;
      out_valid_q <= v2_q;
      if (v2_q) begin
        dout_q     <= dout_d;
        dout_idx_q <= dout_idx_d;
      end
    end
  end

`ifdef RANK_ORDER_FILTER_MINMAX_EN
  logic [WIDTH-1:0] dmin_q, dmin_d, dmax_q, dmax_d;

  assign dmin = dmin_q;
  assign dmax = dmax_q;

  always_comb begin
    dmin_d = dmin_q;
    dmax_d = dmax_q;
    for (int j = 0; j < N; j++) begin
      if (rank2_q[j] == '0) dmin_d = win2_q[j];
      if (rank2_q[j] == RMAX) dmax_d = win2_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmin_q <= '0;
      dmax_q <= '0;
    end else if (adv && v2_q) begin
      dmin_q <= dmin_d;
      dmax_q <= dmax_d;
    end
  end
`endif

endmodule

// File: tb/tb_rank_order_filter.sv
// Directed and streaming checks for rank_order_filter, including backpressure and mid-stream reset.
// The dmin/dmax checks are compiled in when RANK_ORDER_FILTER_MINMAX_EN is defined.
module tb_rank_order_filter;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned N     = 9;
  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned NW    = N * WIDTH;

  typedef struct {
    logic [NW-1:0]    win;
    logic [RW-1:0]    rsel;
    logic [WIDTH-1:0] dat;
    logic [RW-1:0]    idx;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] dat;
    logic [RW-1:0]    idx;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NW-1:0]    din;
  logic [RW-1:0]    rank_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic [RW-1:0]    dout_idx;
`ifdef RANK_ORDER_FILTER_MINMAX_EN
  logic [WIDTH-1:0] dmin;
  logic [WIDTH-1:0] dmax;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rank_order_filter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .rank_sel  (rank_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .dout_idx  (dout_idx)
`ifdef RANK_ORDER_FILTER_MINMAX_EN
    ,
    .dmin      (dmin),
    .dmax      (dmax)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".dout"}, 32'(dout), 32'(e.dat));
    chk({tag, ".idx"}, 32'(dout_idx), 32'(e.idx));
`ifdef RANK_ORDER_FILTER_MINMAX_EN
    chk({tag, ".dmin"}, 32'(dmin), 32'(e.mn));
    chk({tag, ".dmax"}, 32'(dmax), 32'(e.mx));
`endif
  endtask

  function automatic logic [NW-1:0] mk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
    int a[9];
    logic [NW-1:0] w;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int k = 0; k < 9; k++) w[k*WIDTH +: WIDTH] = WIDTH'(a[k]);
    return w;
  endfunction

  function automatic logic [NW-1:0] rand_win();
    logic [NW-1:0] w;
    int unsigned hi;
    hi = ($urandom_range(0, 1) != 0) ? 32'd7 : 32'd4095;
    for (int k = 0; k < N; k++) w[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, hi));
    return w;
  endfunction

  // Reference: stable insertion sort of indices by value, then pick the clamped rank.
  function automatic exp_t ref_sel(input logic [NW-1:0] w, input logic [RW-1:0] rs);
    exp_t e;
    int idx[N];
    logic [WIDTH-1:0] v[N];
    int r;
    for (int k = 0; k < N; k++) begin
      idx[k] = k;
      v[k]   = w[k*WIDTH +: WIDTH];
    end
    for (int i = 1; i < N; i++) begin
      int t;
      int j;
      t = idx[i];
      j = i - 1;
      while (j >= 0) begin
        if (v[idx[j]] <= v[t]) break;
        idx[j+1] = idx[j];
        j--;
      end
      idx[j+1] = t;
    end
    r     = (int'(rs) > N - 1) ? N - 1 : int'(rs);
    e.dat = v[idx[r]];
    e.idx = RW'(idx[r]);
    e.mn  = v[idx[0]];
    e.mx  = v[idx[N-1]];
    return e;
  endfunction

  // One isolated window: checks the 3-cycle latency and the selected result.
  task automatic run_one(input string tag, input vec_t v);
    int lat;
    exp_t e;
    in_valid  = 1'b1;
    din       = v.win;
    rank_sel  = v.rsel;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd3);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    e.dat = v.dat;
    e.idx = v.idx;
    e.mn  = v.mn;
    e.mx  = v.mx;
    chk_out(tag, e);
    @(negedge clk);
  endtask

  // Back-to-back random windows with an optional out_ready stall window.
  task automatic stream(input string tag, input int nwin, input int stall_at, input int stall_len);
    exp_t q[$];
    exp_t e;
    logic [NW-1:0] w;
    logic [RW-1:0] rs;
    int sent, got, cyc, first, last;
    logic stall_prev;
    logic [WIDTH-1:0] held_d;
    logic [RW-1:0] held_i;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    stall_prev = 1'b0; held_d = '0; held_i = '0;
    w  = rand_win();
    rs = RW'($urandom_range(0, 15));
    while (got < nwin && cyc < 300) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (sent < nwin);
      din       = w;
      rank_sel  = rs;
      #1;
      if (out_valid && stall_prev) begin
        chk({tag, ".stall_dout"}, 32'(dout), 32'(held_d));
        chk({tag, ".stall_idx"}, 32'(dout_idx), 32'(held_i));
      end
      if (out_valid && !out_ready) begin
        chk({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
        held_d = dout;
        held_i = dout_idx;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk({tag, ".expected_pending"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_out(tag, e);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_sel(w, rs));
        sent++;
        w  = rand_win();
        rs = RW'($urandom_range(0, 15));
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, ".count"}, 32'(got), 32'(nwin));
    chk({tag, ".leftover"}, 32'(q.size()), 32'd0);
    chk({tag, ".first_latency"}, 32'(first), 32'd3);
    chk({tag, ".span"}, 32'(last - first), 32'(nwin - 1 + stall_len));
    for (int k = 0; k < 4; k++) begin
      #1;
      chk({tag, ".drained"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  vec_t tbl[9];

  initial begin
    logic [NW-1:0] wm, wt;
    wm = mk(9, 1, 8, 2, 7, 3, 6, 4, 5);
    wt = mk(5, 5, 5, 1, 1, 1, 9, 9, 9);
    tbl[0] = '{wm, 4'd4, 12'd5, 4'd8, 12'd1, 12'd9};
    tbl[1] = '{wm, 4'd0, 12'd1, 4'd1, 12'd1, 12'd9};
    tbl[2] = '{wm, 4'd8, 12'd9, 4'd0, 12'd1, 12'd9};
    tbl[3] = '{wm, 4'd15, 12'd9, 4'd0, 12'd1, 12'd9};
    tbl[4] = '{mk(160, 160, 160, 160, 160, 160, 160, 160, 160), 4'd4,
               12'h0A0, 4'd4, 12'h0A0, 12'h0A0};
    tbl[5] = '{wt, 4'd4, 12'd5, 4'd1, 12'd1, 12'd9};
    tbl[6] = '{wt, 4'd0, 12'd1, 4'd3, 12'd1, 12'd9};
    tbl[7] = '{wt, 4'd8, 12'd9, 4'd8, 12'd1, 12'd9};
    tbl[8] = '{wt, 4'd15, 12'd9, 4'd8, 12'd1, 12'd9};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0; rank_sel = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.dout", 32'(dout), 32'd0);
    chk("reset.idx", 32'(dout_idx), 32'd0);
`ifdef RANK_ORDER_FILTER_MINMAX_EN
    chk("reset.dmin", 32'(dmin), 32'd0);
    chk("reset.dmax", 32'(dmax), 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_one($sformatf("vec%0d", i), tbl[i]);

    stream("stream", 20, 1000, 0);
    stream("stall", 16, 8, 5);

    // Three windows accepted, then reset while the first is at the output.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      din      = rand_win();
      rank_sel = RW'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.dout", 32'(dout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("midrst.no_stale", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    run_one("after_rst", tbl[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
